// File: rtl/mant_mul_pkg.sv
// Shared types and constants for the mantissa multiplier scheduler slice.
// Holds the requester tag format and the round-robin pick used by the top.
package mant_mul_pkg;

    localparam int MANT_W = 24;
    localparam int PROD_W = 48;
    localparam int NREQ   = 2;

    typedef logic req_id_t;

    typedef struct packed {
        logic    v;
        req_id_t id;
    } tag_t;

    // On a tie the requester that was not granted most recently wins
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] elig, input req_id_t last);
        logic [NREQ-1:0] g;
        case (elig)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = (last == 1'b1) ? 2'b01 : 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mant_mul_sched_chk.sv
// Simulation-only checks for the scheduler: buffer overflow and grant exclusivity.
// Holds no design state; instantiated by the top.
module mant_mul_sched_chk
    import mant_mul_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    input logic [NREQ-1:0] push,
    input logic [NREQ-1:0] full,
    input logic [NREQ-1:0] req_ready
);

    // Credits must make a write into a full buffer impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (push & full) == {NREQ{1'b0}})
        else $error("result buffer written while full");

    // At most one operand pair is granted per cycle
    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready))
        else $error("more than one grant in a cycle");

endmodule

// File: rtl/mant_rsp_fifo.sv
// Per-requester result buffer: DEPTH x PROD_W synchronous FIFO.
// The head entry is presented directly on data_out.
module mant_rsp_fifo
    import mant_mul_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [PROD_W-1:0] data_in,
    input  logic              pop,
    output logic [PROD_W-1:0] data_out,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic [PROD_W-1:0] mem_r [DEPTH];
    logic              do_push_s;
    logic              do_pop_s;

    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign empty     = (wr_ptr_r == rd_ptr_r);
    // Pointers carry one wrap bit so full and empty are distinguishable
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign data_out  = mem_r[rd_ptr_r[AW-1:0]];

    // Storage and pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= {PROD_W{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= data_in;
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mant_mul_sched.sv
// Shares one pipelined 24x24 mantissa multiplier between two requesters with
// round-robin arbitration, credit flow control and per-requester result buffers.
module mant_mul_sched
    import mant_mul_pkg::*;
#(
    parameter int LAT   = 3,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][MANT_W-1:0] req_opa,
    input  logic [NREQ-1:0][MANT_W-1:0] req_opb,
    output logic                        mul_issue,
    output logic [MANT_W-1:0]           mul_opa,
    output logic [MANT_W-1:0]           mul_opb,
    input  logic [PROD_W-1:0]           mul_p,
    output logic [NREQ-1:0]             rsp_valid,
    input  logic [NREQ-1:0]             rsp_ready,
    output logic [NREQ-1:0][PROD_W-1:0] rsp_p,
    output logic                        busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [NREQ-1:0] elig_s;
    logic [NREQ-1:0] grant_s;
    logic [NREQ-1:0] req_hs_s;
    logic [NREQ-1:0] rsp_hs_s;
    logic [NREQ-1:0] push_s;
    logic [NREQ-1:0] fifo_empty_s;
    logic [NREQ-1:0] fifo_full_s;
    logic            tag_any_s;
    req_id_t         gnt_id_s;
    req_id_t         last_r;
    tag_t            cap_s;
    tag_t            tag_r [LAT+1];
    logic [CW-1:0]   credit_r [NREQ];

    // Stage 0 of the tag pipe shadows the operand registers, stage LAT lines up with mul_p
    assign mul_issue = tag_r[0].v;
    assign cap_s     = tag_r[LAT];
    assign gnt_id_s  = req_id_t'(grant_s[1]);
    assign grant_s   = rr_pick(elig_s, last_r);
    // Grants are held off while reset is asserted
    assign req_ready = grant_s & {NREQ{rst_n}};
    assign req_hs_s  = req_valid & req_ready;
    assign rsp_valid = ~fifo_empty_s;
    assign rsp_hs_s  = rsp_valid & rsp_ready;
    assign busy      = tag_any_s | (|rsp_valid);

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign elig_s[gi] = req_valid[gi] & (credit_r[gi] != {CW{1'b0}});

        mant_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push_s[gi]),
            .data_in  (mul_p),
            .pop      (rsp_ready[gi]),
            .data_out (rsp_p[gi]),
            .empty    (fifo_empty_s[gi]),
            .full     (fifo_full_s[gi])
        );
    end

    // Route the returning product to the buffer of the requester that issued it
    always_comb begin
        push_s = {NREQ{1'b0}};
        if (cap_s.v) begin
            push_s[cap_s.id] = 1'b1;
        end else begin
            push_s = {NREQ{1'b0}};
        end
    end

    // Any valid tag means a product is still inside the multiplier
    always_comb begin
        tag_any_s = 1'b0;
        for (int k = 0; k <= LAT; k++) begin
            tag_any_s = tag_any_s | tag_r[k].v;
        end
    end

    // Operand registers and round-robin history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_opa <= {MANT_W{1'b0}};
            mul_opb <= {MANT_W{1'b0}};
            last_r  <= 1'b1;
        end else if (|req_hs_s) begin
            mul_opa <= req_opa[gnt_id_s];
            mul_opb <= req_opb[gnt_id_s];
            last_r  <= gnt_id_s;
        end
    end

    // Tag pipe tracking which requester owns each in-flight product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LAT; k++) begin
                tag_r[k] <= '{v: 1'b0, id: 1'b0};
            end
        end else begin
            tag_r[0] <= '{v: |req_hs_s, id: gnt_id_s};
            for (int k = 1; k <= LAT; k++) begin
                tag_r[k] <= tag_r[k-1];
            end
        end
    end

    // Credit counters: one per free result-buffer slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                credit_r[i] <= CW'(DEPTH);
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({req_hs_s[i], rsp_hs_s[i]})
                    2'b10:   credit_r[i] <= credit_r[i] - CW'(1);
                    2'b01:   credit_r[i] <= credit_r[i] + CW'(1);
                    default: credit_r[i] <= credit_r[i];
                endcase
            end
        end
    end

    mant_mul_sched_chk u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .full      (fifo_full_s),
        .req_ready (req_ready)
    );

endmodule

// File: tb/tb_mant_mul_sched.sv
// Directed and randomised self-checking bench for mant_mul_sched with a LAT-cycle
// behavioural multiplier; expected products come from hand-computed constants or operands.
module tb_mant_mul_sched;

    localparam int LAT   = 3;
    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_ready;
    logic [1:0][23:0]  req_opa = '0;
    logic [1:0][23:0]  req_opb = '0;
    logic              mul_issue;
    logic [23:0]       mul_opa;
    logic [23:0]       mul_opb;
    logic [47:0]       mul_p;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready = 2'b00;
    logic [1:0][47:0]  rsp_p;
    logic              busy;

    logic [47:0]       mpipe [LAT];
    logic [47:0]       q0 [$];
    logic [47:0]       q1 [$];
    logic              hold_prev [2];
    logic [47:0]       prev_p [2];
    int                checks_n = 0;
    int                errors_n = 0;

    mant_mul_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opa   (req_opa),
        .req_opb   (req_opb),
        .mul_issue (mul_issue),
        .mul_opa   (mul_opa),
        .mul_opb   (mul_opb),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: product of the registered operands, LAT cycles later
    always @(posedge clk) begin
        mpipe[0] <= {24'd0, mul_opa} * {24'd0, mul_opb};
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_p = mpipe[LAT-1];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One cycle of scoreboarding: order, exactly-once delivery and head stability
    task automatic sb_cycle();
        logic [47:0] e;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (hold_prev[i] && rsp_valid[i]) check_val("rsp_hold", 64'(rsp_p[i]), 64'(prev_p[i]));
            if (rsp_valid[i] && rsp_ready[i]) begin
                if (i == 0) begin
                    check_val("rsp_pending0", 64'(q0.size() != 0), 64'd1);
                    if (q0.size() != 0) begin
                        e = q0.pop_front();
                        check_val("rsp_order0", 64'(rsp_p[0]), 64'(e));
                    end
                end else begin
                    check_val("rsp_pending1", 64'(q1.size() != 0), 64'd1);
                    if (q1.size() != 0) begin
                        e = q1.pop_front();
                        check_val("rsp_order1", 64'(rsp_p[1]), 64'(e));
                    end
                end
            end
            if (req_valid[i] && req_ready[i]) begin
                e = {24'd0, req_opa[i]} * {24'd0, req_opb[i]};
                if (i == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
            hold_prev[i] = rsp_valid[i] && !rsp_ready[i];
            prev_p[i]    = rsp_p[i];
        end
    endtask

    initial begin
        int hs;
        int r0;
        int r1;
        logic stale;
        logic [47:0] exp0 [2];
        logic [47:0] exp1 [2];

        hold_prev[0] = 1'b0;
        hold_prev[1] = 1'b0;
        prev_p[0]    = 48'd0;
        prev_p[1]    = 48'd0;

        // Reset values, with requests presented during reset
        req_valid = 2'b11;
        #12;
        check_val("rst_req_ready", 64'(req_ready), 64'd0);
        check_val("rst_mul_issue", 64'(mul_issue), 64'd0);
        check_val("rst_mul_opa", 64'(mul_opa), 64'd0);
        check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("rst_rsp_p0", 64'(rsp_p[0]), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);

        // Single request latency and full-scale product
        reset_dut();
        req_valid = 2'b01; req_opa[0] = 24'hFFFFFF; req_opb[0] = 24'hFFFFFF; rsp_ready = 2'b01;
        @(negedge clk);
        check_val("t1_grant", 64'(req_ready), 64'd1);
        tick(); req_valid = 2'b00;
        @(negedge clk);
        check_val("t1_issue", 64'(mul_issue), 64'd1);
        check_val("t1_opa", 64'(mul_opa), 64'hFFFFFF);
        check_val("t1_opb", 64'(mul_opb), 64'hFFFFFF);
        check_val("t1_busy", 64'(busy), 64'd1);
        tick(); tick(); tick();
        @(negedge clk);
        check_val("t1_early", 64'(rsp_valid), 64'd0);
        tick();
        @(negedge clk);
        check_val("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        check_val("t1_rsp_p", 64'(rsp_p[0]), 64'hFFFFFE000001);
        tick();
        @(negedge clk);
        check_val("t1_drained", 64'(rsp_valid), 64'd0);
        check_val("t1_idle", 64'(busy), 64'd0);

        // Alternating grants and per-requester ordering
        reset_dut();
        exp0[0] = 48'h00000000000F; exp0[1] = 48'h00000000000E;
        exp1[0] = 48'h400000000000; exp1[1] = 48'h600000000000;
        req_opa[0] = 24'h000003; req_opb[0] = 24'h000005;
        req_opa[1] = 24'h800000; req_opb[1] = 24'h800000;
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if (k >= 1) begin req_opa[0] = 24'h000002; req_opb[0] = 24'h000007; end
            if (k >= 2) req_opa[1] = 24'hC00000;
            @(negedge clk);
            check_val($sformatf("t2_grant%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            tick();
        end
        req_valid = 2'b00;
        r0 = 0; r1 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid[0]) begin
                if (r0 < 2) check_val($sformatf("t2_p0_%0d", r0), 64'(rsp_p[0]), 64'(exp0[r0]));
                r0++;
            end
            if (rsp_valid[1]) begin
                if (r1 < 2) check_val($sformatf("t2_p1_%0d", r1), 64'(rsp_p[1]), 64'(exp1[r1]));
                r1++;
            end
            tick();
        end
        check_val("t2_count0", 64'(r0), 64'd2);
        check_val("t2_count1", 64'(r1), 64'd2);

        // Credit exhaustion with a stalled consumer, then one returned credit
        reset_dut();
        req_valid = 2'b01; req_opa[0] = 24'h000010; req_opb[0] = 24'h000010;
        hs = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) hs++;
            tick();
            if (k == 0) begin req_opa[0] = 24'h000020; req_opb[0] = 24'h000020; end
        end
        check_val("t3_hs", 64'(hs), 64'd2);
        rsp_ready = 2'b01;
        @(negedge clk);
        check_val("t3_blocked", 64'(req_ready[0]), 64'd0);
        check_val("t3_head", 64'(rsp_p[0]), 64'h100);
        tick(); rsp_ready = 2'b00;
        @(negedge clk);
        check_val("t3_regrant", 64'(req_ready[0]), 64'd1);
        check_val("t3_next_head", 64'(rsp_p[0]), 64'h400);
        tick();
        @(negedge clk);
        check_val("t3_reblocked", 64'(req_ready[0]), 64'd0);
        req_valid = 2'b00; rsp_ready = 2'b11;
        for (int k = 0; k < 20 && busy; k++) tick();
        check_val("t3_drain", 64'(busy), 64'd0);

        // Same-cycle credit return and request for requester 1
        reset_dut();
        req_valid = 2'b10; req_opa[1] = 24'h000003; req_opb[1] = 24'h000003;
        repeat (9) tick();
        @(negedge clk);
        check_val("t4_blocked", 64'(req_ready), 64'd0);
        check_val("t4_full", 64'(rsp_valid), 64'd2);
        tick(); req_valid = 2'b00; rsp_ready = 2'b10;
        tick(); req_valid = 2'b10; rsp_ready = 2'b10;
        @(negedge clk);
        check_val("t4_both_grant", 64'(req_ready), 64'd2);
        check_val("t4_both_rsp", 64'(rsp_valid), 64'd2);
        tick(); rsp_ready = 2'b00;
        @(negedge clk);
        check_val("t4_credit_kept", 64'(req_ready), 64'd2);
        tick();
        @(negedge clk);
        check_val("t4_credit_gone", 64'(req_ready), 64'd0);

        // Random traffic with scoreboard, including random rsp_ready toggling
        reset_dut();
        for (int n = 0; n < 10000; n++) begin
            req_valid  = 2'($urandom_range(0, 3));
            rsp_ready  = 2'($urandom_range(0, 3));
            req_opa[0] = 24'($urandom); req_opb[0] = 24'($urandom);
            req_opa[1] = 24'($urandom); req_opb[1] = 24'($urandom);
            sb_cycle();
            tick();
        end
        req_valid = 2'b00; rsp_ready = 2'b11;
        for (int n = 0; n < 20; n++) begin
            sb_cycle();
            tick();
        end
        check_val("rnd_left0", 64'(q0.size()), 64'd0);
        check_val("rnd_left1", 64'(q1.size()), 64'd0);
        check_val("rnd_idle", 64'(busy), 64'd0);

        // Asynchronous reset with products in flight
        reset_dut();
        req_valid = 2'b11; req_opa = '0; req_opb = '0;
        req_opa[0] = 24'h000005; req_opb[0] = 24'h000005;
        tick(); tick(); req_valid = 2'b00;
        @(negedge clk);
        check_val("t5_inflight", 64'(busy), 64'd1);
        tick();
        #2;
        req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        check_val("t5_req_ready", 64'(req_ready), 64'd0);
        check_val("t5_mul_issue", 64'(mul_issue), 64'd0);
        check_val("t5_mul_opa", 64'(mul_opa), 64'd0);
        check_val("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("t5_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
        stale = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) stale = 1'b1;
            tick();
        end
        check_val("t5_stale", 64'(stale), 64'd0);
        req_valid = 2'b01; rsp_ready = 2'b00; hs = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) hs++;
            tick();
        end
        check_val("t5_credits", 64'(hs), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

endmodule
